// File: rtl/register_bank_arbiter.sv
// register_bank_arbiter
// Arbitrates two request ports (A and B) onto a single external register bank.
// Each port issues one of four operations: read Ry, write Rx, copy Rx <- Ry,
// or the reserved code, which is acknowledged with an error and never touches
// the bank. When both ports request together, the FAIR parameter selects the
// policy: round-robin (FAIR=1) or fixed priority with A always winning (FAIR=0).
//
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   req_x, op_x, rx_x, ry_x,    per-port request, opcode, destination select,
//   ind_x, wdata_x              source select, indirect flag, write data
//   ack_x, rdata_x, err_x       per-port completion pulse, result, error
//   busy                        high whenever a transaction is in flight
//   bank_read_en/write_en       bank strobes (forced low while reset is high)
//   bank_rx_sel/ry_sel          bank register selectors
//   bank_indirect_en            bank indirect mode for the Ry read
//   bank_wdata                  bank write data
//   bank_bus_data               bank read data, used only while reading
module register_bank_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [1:0] op_a,
  input  logic [1:0] op_b,
  input  logic [2:0] rx_a,
  input  logic [2:0] rx_b,
  input  logic [2:0] ry_a,
  input  logic [2:0] ry_b,
  input  logic       ind_a,
  input  logic       ind_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [7:0] rdata_a,
  output logic [7:0] rdata_b,
  output logic       err_a,
  output logic       err_b,
  output logic       busy,
  output logic       bank_read_en,
  output logic       bank_write_en,
  output logic [2:0] bank_rx_sel,
  output logic [2:0] bank_ry_sel,
  output logic       bank_indirect_en,
  output logic [7:0] bank_wdata,
  input  logic [7:0] bank_bus_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    COPY_WR = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t     state_q, state_d;
  logic       lastGrantB_q, lastGrantB_d;
  logic       grantB_q, grantB_d;
  logic [1:0] op_q, op_d;
  logic [2:0] rx_q, rx_d;
  logic [2:0] ry_q, ry_d;
  logic       ind_q, ind_d;
  logic [7:0] bankWdata_q, bankWdata_d;
  logic [7:0] result_q, result_d;
  logic [7:0] rdataA_q, rdataA_d;
  logic [7:0] rdataB_q, rdataB_d;
  logic       pickB;
  logic       readEn;
  logic       writeEn;

  // Winner selection. A lone requester always wins. Under contention the
  // round-robin policy hands the grant to whichever port did not win last,
  // while fixed priority always picks A.
  always_comb begin
    if (req_a && req_b) begin
      pickB = FAIR ? ~lastGrantB_q : 1'b0;
    end else begin
      pickB = req_b;
    end
  end

  // Next-state and bank strobe logic. The winner's request fields are latched
  // once in IDLE and then stay frozen for the whole transaction. The write data
  // register doubles as the bank write data output, so for a copy it is
  // reloaded with the value read in ACCESS and COPY_WR simply writes it back.
  // rdata for the granted port is loaded on the edge that enters RESP, so it
  // is already valid in the ack cycle and holds afterwards.
  always_comb begin
    state_d      = state_q;
    lastGrantB_d = lastGrantB_q;
    grantB_d     = grantB_q;
    op_d         = op_q;
    rx_d         = rx_q;
    ry_d         = ry_q;
    ind_d        = ind_q;
    bankWdata_d  = bankWdata_q;
    result_d     = result_q;
    rdataA_d     = rdataA_q;
    rdataB_d     = rdataB_q;
    readEn       = 1'b0;
    writeEn      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          grantB_d     = pickB;
          lastGrantB_d = pickB;
          op_d         = pickB ? op_b    : op_a;
          rx_d         = pickB ? rx_b    : rx_a;
          ry_d         = pickB ? ry_b    : ry_a;
          ind_d        = pickB ? ind_b   : ind_a;
          bankWdata_d  = pickB ? wdata_b : wdata_a;
          state_d      = (op_d == OP_RSVD) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        case (op_q)
          OP_READ: begin
            readEn   = 1'b1;
            result_d = bank_bus_data;
            state_d  = RESP;
          end
          OP_WRITE: begin
            writeEn  = 1'b1;
            result_d = bankWdata_q;
            state_d  = RESP;
          end
          OP_COPY: begin
            readEn      = 1'b1;
            result_d    = bank_bus_data;
            bankWdata_d = bank_bus_data;
            state_d     = COPY_WR;
          end
          default: begin
            state_d = RESP;
          end
        endcase
      end
      COPY_WR: begin
        writeEn = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == RESP) begin
      if (grantB_d) begin
        rdataB_d = result_d;
      end else begin
        rdataA_d = result_d;
      end
    end
  end

  // State register. Reset abandons any transaction in flight without an ack
  // and leaves A as the winner of the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lastGrantB_q <= 1'b1;
      grantB_q     <= 1'b0;
      op_q         <= 2'b00;
      rx_q         <= 3'd0;
      ry_q         <= 3'd0;
      ind_q        <= 1'b0;
      bankWdata_q  <= 8'h00;
      result_q     <= 8'h00;
      rdataA_q     <= 8'h00;
      rdataB_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      lastGrantB_q <= lastGrantB_d;
      grantB_q     <= grantB_d;
      op_q         <= op_d;
      rx_q         <= rx_d;
      ry_q         <= ry_d;
      ind_q        <= ind_d;
      bankWdata_q  <= bankWdata_d;
      result_q     <= result_d;
      rdataA_q     <= rdataA_d;
      rdataB_q     <= rdataB_d;
    end
  end

  // Strobes are gated by reset combinationally so that no bank write can
  // commit on a reset edge, even in the middle of COPY_WR.
  assign bank_read_en     = readEn & ~reset;
  assign bank_write_en    = writeEn & ~reset;
  assign bank_rx_sel      = rx_q;
  assign bank_ry_sel      = ry_q;
  assign bank_indirect_en = ind_q;
  assign bank_wdata       = bankWdata_q;

  assign ack_a   = (state_q == RESP) && !grantB_q;
  assign ack_b   = (state_q == RESP) && grantB_q;
  assign err_a   = ack_a && (op_q == OP_RSVD);
  assign err_b   = ack_b && (op_q == OP_RSVD);
  assign rdata_a = rdataA_q;
  assign rdata_b = rdataB_q;
  assign busy    = (state_q != IDLE);

endmodule
